bnn_sequencer: RTL

BNN_SEQUENCER -- requirements
Module: bnn_sequencer

---
 rtl/bnn_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bnn_sequencer.sv
// Layer-job sequencer that drives INI/ACC/POOL/NORM commands into a binary NN datapath.
// Optional BNN_SEQ_PERF_EN adds stall_cnt_o, a saturating count of ACC-state stall cycles.
module bnn_sequencer #(
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  acc_len_i,
  input  logic [3:0]  pool_len_i,
  input  logic [15:0] base_addr_i,
  input  logic [15:0] norm_addr_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  output logic        bnn_en_o,
  output logic [2:0]  bnn_operator_o,
  output logic [31:0] bnn_addr_o,
  output logic [31:0] bnn_data_o,
  input  logic [31:0] bnn_result_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
`ifdef BNN_SEQ_PERF_EN
  output logic [15:0] stall_cnt_o,
`endif
  output logic [31:0] result_o
);

  localparam int unsigned AccW   = 8;
  localparam int unsigned PoolW  = 4;
  localparam int unsigned AddrW  = 16;
  localparam int unsigned DataW  = 32;
  localparam int unsigned DrainW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  typedef enum logic [2:0] {
    OP_INI  = 3'd0,
    OP_ACC  = 3'd1,
    OP_POOL = 3'd2,
    OP_NORM = 3'd3,
    OP_IDLE = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_DRAIN, S_DONE
  } state_e;

  typedef struct packed {
    logic             en;
    op_e              op;
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
  } cmd_t;

  localparam cmd_t CmdIdle = '{en: 1'b0, op: OP_IDLE, addr: '0, data: '0};

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [AccW-1:0]   acc_len_q, acc_len_d, acc_cnt_q, acc_cnt_d;
  logic [PoolW-1:0]  pool_len_q, pool_len_d, pool_cnt_q, pool_cnt_d;
  logic [AddrW-1:0]  addr_q, addr_d, norm_addr_q, norm_addr_d;
  logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
  logic [DataW-1:0]  result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              in_ready_q, in_ready_d;

  // Next-state and command generation; commands trail the state by one cycle.
  always_comb begin
    state_d     = state_q;
    cmd_d       = CmdIdle;
    acc_len_d   = acc_len_q;
    pool_len_d  = pool_len_q;
    norm_addr_d = norm_addr_q;
    addr_d      = addr_q;
    acc_cnt_d   = acc_cnt_q;
    pool_cnt_d  = pool_cnt_q;
    drain_cnt_d = drain_cnt_q;
    result_d    = result_q;
    done_d      = 1'b0;
    error_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if ((acc_len_i != '0) && (pool_len_i != '0)) begin
            state_d     = S_INI;
            acc_len_d   = acc_len_i;
            pool_len_d  = pool_len_i;
            norm_addr_d = norm_addr_i;
            addr_d      = base_addr_i;
            acc_cnt_d   = '0;
            pool_cnt_d  = '0;
          end else begin
            done_d  = 1'b1;
            error_d = 1'b1;
          end
        end
      end
      S_INI: begin
        cmd_d.en   = 1'b1;
        cmd_d.op   = OP_INI;
        cmd_d.addr = addr_q;
        state_d    = S_ACC;
      end
      S_ACC: begin
        if (in_valid_i && in_ready_q) begin
          cmd_d.en   = 1'b1;
          cmd_d.op   = OP_ACC;
          cmd_d.addr = addr_q;
          cmd_d.data = in_data_i;
          addr_d     = addr_q + AddrW'(1);
          if (acc_cnt_q == acc_len_q - AccW'(1)) begin
            acc_cnt_d = '0;
            state_d   = S_POOL;
          end else begin
            acc_cnt_d = acc_cnt_q + AccW'(1);
          end
        end
      end
      S_POOL: begin
        cmd_d.en = 1'b1;
        cmd_d.op = OP_POOL;
        if (pool_cnt_q == pool_len_q - PoolW'(1)) begin
          pool_cnt_d = '0;
          state_d    = S_NORM;
        end else begin
          pool_cnt_d = pool_cnt_q + PoolW'(1);
          state_d    = S_ACC;
        end
      end
      S_NORM: begin
        cmd_d.en    = 1'b1;
        cmd_d.op    = OP_NORM;
        cmd_d.addr  = norm_addr_q;
        drain_cnt_d = '0;
        state_d     = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt_q == DrainW'(DRAIN_CYC - 1)) begin
          result_d = bnn_result_i;
          state_d  = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DrainW'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) done_d = 1'b1;
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_ACC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= CmdIdle;
      acc_len_q   <= '0;
      pool_len_q  <= '0;
      norm_addr_q <= '0;
      addr_q      <= '0;
      acc_cnt_q   <= '0;
      pool_cnt_q  <= '0;
      drain_cnt_q <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      acc_len_q   <= acc_len_d;
      pool_len_q  <= pool_len_d;
      norm_addr_q <= norm_addr_d;
      addr_q      <= addr_d;
      acc_cnt_q   <= acc_cnt_d;
      pool_cnt_q  <= pool_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef BNN_SEQ_PERF_EN
  logic        start_ok_c;
  logic [15:0] stall_cnt_q;

  assign start_ok_c = (state_q == S_IDLE) && start_i && (acc_len_i != '0) && (pool_len_i != '0);

  // Saturating count of ACC cycles without input data, restarted per accepted job.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (start_ok_c) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_ACC) && !in_valid_i && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  assign bnn_en_o       = cmd_q.en;
  assign bnn_operator_o = cmd_q.op;
  assign bnn_addr_o     = {16'h0000, cmd_q.addr};
  assign bnn_data_o     = cmd_q.data;
  assign in_ready_o     = in_ready_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign error_o        = error_q;
  assign result_o       = result_q;

endmodule
